// File: rtl/fp_normalize_round.sv
// Normalize / round-to-nearest-even / pack stage for the binary32 FPU datapath.
// Two register stages (normalize, round+pack) with valid/ready flow control and no skid buffer.
module fp_normalize_round #(
   parameter int MANT_W = 28,
   parameter int LZ_W   = 6
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic                    in_sign,
   input  logic signed [9:0]       in_exp,
   input  logic [MANT_W-1:0]       in_mant,
   input  logic [LZ_W-1:0]         in_lz,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [31:0]             out_result,
   output logic                    out_overflow,
   output logic                    out_underflow,
   output logic                    out_inexact
);

   localparam int EXP_W = 11;

   // Packs {result[31:0], overflow, underflow, inexact}. The mantissa argument
   // excludes the leading one, which normalization has placed at the carry position.
   function automatic logic [34:0] round_pack(
      input logic                    sign,
      input logic signed [EXP_W-1:0] e,
      input logic [MANT_W-2:0]       m,
      input logic                    zero
   );
      logic [22:0]             f;
      logic                    g;
      logic                    s;
      logic                    up;
      logic [23:0]             f_inc;
      logic signed [EXP_W:0]   e_r;
      logic [34:0]             r;
      f     = m[26:4];
      g     = m[3];
      s     = |m[2:0];
      up    = g & (s | f[0]);
      f_inc = {1'b0, f} + {23'd0, up};
      e_r   = {e[EXP_W-1], e} + {{EXP_W{1'b0}}, f_inc[23]};
      if (zero)
         r = {sign, 31'd0, 3'b000};
      else if (e_r >= 12'sd255)
         r = {sign, 8'hFF, 23'd0, 3'b101};
      else if (e_r <= 12'sd0)
         r = {sign, 31'd0, 3'b011};
      else
         r = {sign, e_r[7:0], f_inc[22:0], 2'b00, g | s};
      return r;
   endfunction

   logic                    r_vld_p1;
   logic                    r_vld_p2;
   logic                    w_adv_p2;
   logic [MANT_W-2:0]       w_mant_p0;
   logic signed [EXP_W-1:0] w_exp_p0;
   logic                    w_zero_p0;

   logic                    r_sign_p1;
   logic [MANT_W-2:0]       r_mant_p1;
   logic signed [EXP_W-1:0] r_exp_p1;
   logic                    r_zero_p1;
   logic [34:0]             w_pack_p1;

   logic [31:0]             r_res_p2;
   logic                    r_ovf_p2;
   logic                    r_unf_p2;
   logic                    r_inx_p2;

   assign w_adv_p2 = !r_vld_p2 | out_ready;
   assign in_ready = !r_vld_p1 | w_adv_p2;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld_p1 <= 1'b0;
         r_vld_p2 <= 1'b0;
      end else begin
         if (in_ready)
            r_vld_p1 <= in_valid;
         if (w_adv_p2)
            r_vld_p2 <= r_vld_p1;
      end
   end

   // Stage 1: left-normalize and re-bias exponent (11-bit signed, cannot wrap)
   assign w_mant_p0 = (MANT_W-1)'(in_mant << in_lz);
   assign w_exp_p0  = {in_exp[9], in_exp} + 11'sd1 - {{(EXP_W-LZ_W){1'b0}}, in_lz};
   assign w_zero_p0 = (in_lz == LZ_W'(MANT_W));

   always_ff @(posedge clk) begin
      if (in_valid & in_ready) begin
         r_sign_p1 <= in_sign;
         r_mant_p1 <= w_mant_p0;
         r_exp_p1  <= w_exp_p0;
         r_zero_p1 <= w_zero_p0;
      end
   end

   // Stage 2: round and pack; output registers reset so they read 0 until the first beat
   assign w_pack_p1 = round_pack(r_sign_p1, r_exp_p1, r_mant_p1, r_zero_p1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_res_p2 <= 32'd0;
         r_ovf_p2 <= 1'b0;
         r_unf_p2 <= 1'b0;
         r_inx_p2 <= 1'b0;
      end else if (r_vld_p1 & w_adv_p2) begin
         {r_res_p2, r_ovf_p2, r_unf_p2, r_inx_p2} <= w_pack_p1;
      end
   end

   assign out_valid     = r_vld_p2;
   assign out_result    = r_res_p2;
   assign out_overflow  = r_ovf_p2;
   assign out_underflow = r_unf_p2;
   assign out_inexact   = r_inx_p2;

endmodule

// File: tb/tb_fp_normalize_round.sv
// Randomized bench for fp_normalize_round: scoreboard fed by a value-level binary32
// rounding model, plus directed latency, backpressure and mid-stream reset cases.
module tb_fp_normalize_round;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              in_valid;
   logic              in_ready;
   logic              in_sign;
   logic signed [9:0] in_exp;
   logic [27:0]       in_mant;
   logic [5:0]        in_lz;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_result;
   logic              out_overflow;
   logic              out_underflow;
   logic              out_inexact;

   int checks = 0;
   int errors = 0;
   logic bp_mode = 1'b0;

   typedef struct packed {
      logic [31:0] res;
      logic        ovf;
      logic        unf;
      logic        inx;
   } exp_t;

   exp_t q[$];
   exp_t stall_snap;
   exp_t got;
   exp_t want;
   logic prev_stall = 1'b0;
   int   inflight;

   always #5 clk = ~clk;

   fp_normalize_round #(.MANT_W(28), .LZ_W(6)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_sign      (in_sign),
      .in_exp       (in_exp),
      .in_mant      (in_mant),
      .in_lz        (in_lz),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_result   (out_result),
      .out_overflow (out_overflow),
      .out_underflow(out_underflow),
      .out_inexact  (out_inexact)
   );

   function automatic logic [5:0] clz(input logic [27:0] m);
      for (int i = 27; i >= 0; i--)
         if (m[i]) return 6'(27 - i);
      return 6'd28;
   endfunction

   // Value = m / 2^26 * 2^(e-127): locate the MSB, keep 24 significant bits, RNE on the rest.
   function automatic exp_t model(input logic s, input int e, input logic [27:0] m);
      exp_t   r;
      int     p;
      int     d;
      int     be;
      longint qv;
      longint rem;
      longint half;
      r = '0;
      if (m == 28'd0) begin
         r.res = {s, 31'd0};
         return r;
      end
      p = 0;
      for (int i = 0; i < 28; i++)
         if (m[i]) p = i;
      be = e + p - 26;
      if (p >= 23) begin
         d    = p - 23;
         qv   = longint'(m) >> d;
         rem  = longint'(m) & ((longint'(1) << d) - 1);
         half = (d > 0) ? (longint'(1) << (d - 1)) : 0;
      end else begin
         qv   = longint'(m) << (23 - p);
         rem  = 0;
         half = 0;
      end
      if (rem != 0 && (rem > half || (rem == half && qv[0])))
         qv = qv + 1;
      if (qv == (longint'(1) << 24)) begin
         qv = qv >> 1;
         be = be + 1;
      end
      r.inx = (rem != 0);
      if (be >= 255) begin
         r.res = {s, 8'hFF, 23'd0};
         r.ovf = 1'b1;
         r.inx = 1'b1;
      end else if (be <= 0) begin
         r.res = {s, 31'd0};
         r.unf = 1'b1;
         r.inx = 1'b1;
      end else begin
         r.res = {s, be[7:0], qv[22:0]};
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] got_v, input logic [63:0] want_v);
      checks++;
      if (got_v !== want_v) begin
         errors++;
         $display("FAIL %s got %h want %h", name, got_v, want_v);
      end
   endtask

   task automatic check_model(input string name, input logic s, input int e, input logic [27:0] m,
                              input logic [31:0] res, input logic [2:0] flags);
      exp_t r;
      r = model(s, e, m);
      chk(name, 64'({r.res, r.ovf, r.unf, r.inx}), 64'({res, flags}));
   endtask

   // Scoreboard / protocol monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         q.delete();
         prev_stall = 1'b0;
      end else begin
         inflight = q.size();
         checks++;
         if (in_ready !== !(inflight == 2 && !out_ready)) begin
            errors++;
            $display("FAIL in_ready got %b inflight %0d out_ready %b", in_ready, inflight, out_ready);
         end
         got = {out_result, out_overflow, out_underflow, out_inexact};
         if (prev_stall) begin
            checks++;
            if (out_valid !== 1'b1 || got !== stall_snap) begin
               errors++;
               $display("FAIL stall_hold got %b/%h want 1/%h", out_valid, got, stall_snap);
            end
         end
         if (inflight == 0) begin
            checks++;
            if (out_valid !== 1'b0) begin
               errors++;
               $display("FAIL empty_valid got %b want 0", out_valid);
            end
         end
         if (out_valid && out_ready && inflight != 0) begin
            want = q.pop_front();
            checks++;
            if (got !== want) begin
               errors++;
               $display("FAIL result got %h want %h", got, want);
            end
         end
         prev_stall = out_valid && !out_ready;
         stall_snap = got;
         if (in_valid && in_ready)
            q.push_back(model(in_sign, int'(in_exp), in_mant));
      end
   end

   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         out_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   task automatic drive_beat(input logic s, input logic signed [9:0] e, input logic [27:0] m);
      int   n;
      logic took;
      in_valid = 1'b1;
      in_sign  = s;
      in_exp   = e;
      in_mant  = m;
      in_lz    = clz(m);
      n        = 0;
      took     = 1'b0;
      do begin
         @(negedge clk);
         took = in_ready && rst_n;
         @(posedge clk);
         #1;
         n++;
      end while (!took && n < 200);
      if (!took) begin
         checks++;
         errors++;
         $display("FAIL accept_timeout got stalled want accepted");
      end
      in_valid = 1'b0;
   endtask

   task automatic random_beat();
      logic [27:0]       m;
      logic signed [9:0] e;
      int                k;
      k = $urandom_range(0, 28);
      m = 28'($urandom);
      m = m >> k;
      if ($urandom_range(0, 9) == 0)
         e = 10'($urandom);
      else
         e = 10'($urandom_range(0, 300)) - 10'd20;
      drive_beat(1'($urandom_range(0, 1)), e, m);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (q.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      chk("drain", 64'(q.size()), 64'd0);
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sign  = 1'b0;
      in_exp   = '0;
      in_mant  = '0;
      in_lz    = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", 64'(out_valid), 64'd0);
      chk("rst_result", 64'(out_result), 64'd0);
      chk("rst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      rst_n = 1'b1;

      check_model("m_one",      0, 127, 28'h4000000, 32'h3F800000, 3'b000);
      check_model("m_two",      0, 127, 28'h8000000, 32'h40000000, 3'b000);
      check_model("m_tie_even", 0, 127, 28'h4000004, 32'h3F800000, 3'b001);
      check_model("m_tie_up",   0, 127, 28'h400000C, 32'h3F800002, 3'b001);
      check_model("m_carry",    0, 127, 28'h7FFFFFF, 32'h40000000, 3'b001);
      check_model("m_ovf",      0, 254, 28'h8000000, 32'h7F800000, 3'b101);
      check_model("m_ovf_rnd",  0, 253, 28'hFFFFFFF, 32'h7F800000, 3'b101);
      check_model("m_unf",      1, 0,   28'h4000000, 32'h80000000, 3'b011);
      check_model("m_min_norm", 0, 1,   28'h4000000, 32'h00800000, 3'b000);
      check_model("m_zero",     1, 127, 28'h0000000, 32'h80000000, 3'b000);

      @(posedge clk);
      #1;
      drive_beat(0, 10'sd127, 28'h4000000);
      chk("lat_stage1", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("lat_stage2", 64'(out_valid), 64'd1);
      chk("lat_result", 64'({out_result, out_overflow, out_underflow, out_inexact}),
          64'({32'h3F800000, 3'b000}));
      drain();

      drive_beat(0, 10'sd127, 28'h8000000);
      drive_beat(0, 10'sd127, 28'h4000004);
      drive_beat(0, 10'sd127, 28'h400000C);
      drive_beat(0, 10'sd127, 28'h7FFFFFF);
      drive_beat(0, 10'sd254, 28'h8000000);
      drive_beat(0, 10'sd253, 28'hFFFFFFF);
      drive_beat(1, 10'sd0,   28'h4000000);
      drive_beat(1, -10'sd5,  28'h4000000);
      drive_beat(0, 10'sd1,   28'h4000000);
      drive_beat(1, 10'sd127, 28'h0000000);
      drain();

      bp_mode = 1'b1;
      drive_beat(0, 10'sd127, 28'h4000000);
      drive_beat(1, 10'sd128, 28'h8000000);
      drive_beat(0, 10'sd127, 28'h400000C);
      drive_beat(1, 10'sd200, 28'h7FFFFFF);
      drive_beat(0, 10'sd254, 28'h8000000);
      drive_beat(1, 10'sd0,   28'h4000000);
      drive_beat(0, 10'sd10,  28'h0000000);
      drive_beat(1, 10'sd127, 28'h4000004);
      for (int i = 0; i < 300; i++)
         random_beat();
      bp_mode = 1'b0;
      drain();

      for (int i = 0; i < 300; i++)
         random_beat();
      drain();

      drive_beat(0, 10'sd127, 28'h4000000);
      drive_beat(0, 10'sd128, 28'h4000000);
      #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", 64'(out_valid), 64'd0);
      chk("mid_rst_result", 64'(out_result), 64'd0);
      chk("mid_rst_flags", 64'({out_overflow, out_underflow, out_inexact}), 64'd0);
      chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("post_rst_idle", 64'(out_valid), 64'd0);
      drive_beat(1, 10'sd130, 28'h8000000);
      chk("post_rst_stage1", 64'(out_valid), 64'd0);
      @(posedge clk);
      #1;
      chk("post_rst_stage2", 64'(out_valid), 64'd1);
      chk("post_rst_result", 64'({out_result, out_overflow, out_underflow, out_inexact}),
          64'({32'hC1800000, 3'b000}));
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
